// File: rtl/arb_req_pkg.sv
// Shared types and default parameters for the round-robin arbitration requester.
package arb_req_pkg;

    typedef enum logic {IDLE, REQ} arb_req_state_t;

    localparam int ARB_REQ_WIDTH    = 8;
    localparam int ARB_REQ_DEPTH    = 4;
    localparam int ARB_REQ_MAX_WAIT = 15;

endpackage

// File: rtl/arb_req_fifo.sv
// Synchronous pending-word FIFO; the caller qualifies push with !full and pop with !empty.
module arb_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arb_requester.sv
// Client endpoint of the 2-way round-robin arbiter: buffers words, requests, drives granted words.
// Optional starvation watchdog enabled by defining ARB_REQ_WATCHDOG_EN.
module arb_requester
    import arb_req_pkg::*;
#(
    parameter int WIDTH    = ARB_REQ_WIDTH,
    parameter int DEPTH    = ARB_REQ_DEPTH,
    parameter int MAX_WAIT = ARB_REQ_MAX_WAIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             req,
    input  logic             gnt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             proto_err,
    output logic             starved
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] head;
    arb_req_state_t   state;

    assign in_ready = !full;
    assign push     = in_valid & in_ready;
    assign req      = (state == REQ);
    assign pop      = req & gnt & !empty;

    arb_req_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (in_data),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (push) state <= REQ;
                REQ:     if (pop && !push && count == CW'(1)) state <= IDLE;
                default: state <= IDLE;
            endcase
            out_valid <= pop;
            if (pop) out_data <= head;
            if (gnt && !req) proto_err <= 1'b1;
        end
    end

`ifdef ARB_REQ_WATCHDOG_EN
    localparam int WW = $clog2(MAX_WAIT + 2);
    localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT + 1);

    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_next;

    always_comb begin
        wait_next = wait_cnt;
        if (state == IDLE || pop) begin
            wait_next = '0;
        end else if (wait_cnt != WAIT_SAT) begin
            wait_next = wait_cnt + 1'b1;
        end
    end

    // starved is registered from the next count so it drops the cycle after a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            starved  <= 1'b0;
        end else begin
            wait_cnt <= wait_next;
            starved  <= (wait_next == WAIT_SAT);
        end
    end
`else
    // constant 0; MAX_WAIT is referenced so the parameter stays used in this build
    assign starved = (MAX_WAIT < 0);
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Directed self-checking bench for arb_requester, including a two-instance round-robin pairing.
module tb_arb_requester;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       req;
    logic       gnt;
    logic       out_valid;
    logic [7:0] out_data;
    logic       proto_err;
    logic       starved;

    logic [1:0] p_in_valid;
    logic [7:0] p_in_data [2];
    logic [1:0] p_in_ready;
    logic [1:0] p_req;
    logic [1:0] p_gnt;
    logic [1:0] p_out_valid;
    logic [7:0] p_out_data [2];
    logic [1:0] p_proto_err;
    logic [1:0] p_starved;
    logic       last_gnt;

    int total = 0;
    int bad   = 0;

`ifdef ARB_REQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    always #5 clk = ~clk;

    arb_requester #(.WIDTH(8), .DEPTH(4), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .req(req), .gnt(gnt), .out_valid(out_valid),
        .out_data(out_data), .proto_err(proto_err), .starved(starved)
    );

    for (genvar g = 0; g < 2; g++) begin : g_pair
        arb_requester #(.WIDTH(8), .DEPTH(4), .MAX_WAIT(15)) u_req (
            .clk(clk), .rst(rst), .in_valid(p_in_valid[g]), .in_data(p_in_data[g]),
            .in_ready(p_in_ready[g]), .req(p_req[g]), .gnt(p_gnt[g]),
            .out_valid(p_out_valid[g]), .out_data(p_out_data[g]),
            .proto_err(p_proto_err[g]), .starved(p_starved[g])
        );
    end

    // Reference 2-way round-robin arbiter feeding the pair
    always_comb begin
        p_gnt = 2'b00;
        if (p_req == 2'b11) p_gnt = last_gnt ? 2'b01 : 2'b10;
        else                p_gnt = p_req;
    end

    always_ff @(posedge clk) begin
        if (rst)             last_gnt <= 1'b1;
        else if (p_gnt[0])   last_gnt <= 1'b0;
        else if (p_gnt[1])   last_gnt <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'hEE;
        gnt        = 1'b0;
        p_in_valid = 2'b00;
        p_in_data[0] = 8'h00;
        p_in_data[1] = 8'h00;

        // 1: reset with in_valid held high
        tick();
        tick();
        check("rst_req", req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 8'h00);
        check("rst_proto_err", proto_err, 0);
        check("rst_starved", starved, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("rst_no_push", req, 0);

        // 2: single word, gnt follows req
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        check("single_req_c1", req, 1);
        check("single_no_out_c1", out_valid, 0);
        gnt = req;
        tick();
        gnt = 1'b0;
        check("single_ov_c2", out_valid, 1);
        check("single_data_c2", out_data, 8'hA5);
        check("single_idle", req, 0);
        tick();
        check("single_ov_drop", out_valid, 0);
        check("single_data_hold", out_data, 8'hA5);

        // 3: fill then drain under continuous grant
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("fill_in_ready", in_ready, 0);
        check("fill_req", req, 1);
        gnt = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("drain_ov", out_valid, 1);
            check("drain_data", out_data, 32'(i));
        end
        gnt = 1'b0;
        check("drain_idle", req, 0);
        check("drain_ready", in_ready, 1);

        // 4: push+pop while full
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h11 + 8'(i);
            tick();
        end
        in_data = 8'h15;
        gnt     = 1'b1;
        check("full_ready_before", in_ready, 0);
        tick();
        gnt = 1'b0;
        check("full_pop_data", out_data, 8'h11);
        check("full_pop_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("full_push_next", in_ready, 0);
        check("full_gap_ov", out_valid, 0);
        gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("full_order", out_data, 32'(8'h12 + 8'(i)));
        end
        gnt = 1'b0;
        check("full_idle", req, 0);

        // 6: protocol error and watchdog
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        check("perr_set", proto_err, 1);
        check("perr_no_ov", out_valid, 0);
        tick();
        check("perr_sticky", proto_err, 1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        in_valid = 1'b0;
        repeat (15) tick();
        check("wd_before", starved, 0);
        tick();
        check("wd_starved", starved, 32'(WD));
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        check("wd_clear", starved, 0);
        check("wd_data", out_data, 8'h77);
        check("perr_still", proto_err, 1);

        // reset mid-operation discards buffered word and clears proto_err
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_req", req, 0);
        check("midrst_perr", proto_err, 0);
        tick();
        check("midrst_stay_idle", req, 0);

        // 5: two instances behind the round-robin arbiter
        p_in_valid   = 2'b11;
        p_in_data[0] = 8'hA0;
        p_in_data[1] = 8'hB0;
        tick();
        for (int k = 0; k < 6; k++) begin
            if (k < 2) begin
                p_in_data[0] = 8'hA1 + 8'(k);
                p_in_data[1] = 8'hB1 + 8'(k);
            end else begin
                p_in_valid = 2'b00;
            end
            tick();
            check("pair_exclusive", p_out_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k % 2 == 0) check("pair_data0", p_out_data[0], 32'(8'hA0 + 8'(k / 2)));
            else            check("pair_data1", p_out_data[1], 32'(8'hB0 + 8'(k / 2)));
        end
        check("pair_idle", p_req, 2'b00);
        check("pair_perr", p_proto_err, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
